viterbi_seq_ctrl: RTL and testbench

//  Frame-level sequencer for the Viterbi decoder back end. Paces symbol intake with a valid/ready handshake and

---
 rtl/viterbi_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_viterbi_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_seq_ctrl.sv
`default_nettype none
// viterbi_seq_ctrl - frame sequencer for the Viterbi back end (rev 1.0).
// Optional macro VITCTRL_STALL_CNT_EN adds the oStallCnt output.
module viterbi_seq_ctrl #(
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 5,
    parameter int TAIL_LEN  = 6,
    parameter int DRAIN_MAX = 256
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [LEN_W-1:0] iFrameLen,
    input  logic             iAbort,
    input  logic             iSymValid,
    output logic             oSymReady,
    output logic             oDecEn,
    output logic             oFlush,
    output logic [CNT_W-1:0] oCounter,
    output logic             oCntZero,
    input  logic             iDecValid,
    output logic             oBusy,
    output logic             oFrameDone,
    output logic             oErr
`ifdef VITCTRL_STALL_CNT_EN
    ,
    output logic [15:0]      oStallCnt
`endif
);

    localparam int WD_W = $clog2(DRAIN_MAX);
    localparam int TL_W = $clog2(TAIL_LEN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0]   step_cnt;
    logic [LEN_W:0]   dec_cnt;
    logic [LEN_W:0]   dec_target;
    logic [LEN_W:0]   last_step;
    logic [TL_W-1:0]  tail_cnt;
    logic [WD_W-1:0]  wdog;
    logic [CNT_W-1:0] counter;
    logic             err_q;
    logic             start_ok;
    logic             dec_en;
    logic             in_frame;
    logic             dec_complete;
    logic             wdog_expire;

    assign start_ok     = (state == S_IDLE) && iStart && (iFrameLen != '0) && !iAbort;
    assign dec_target   = {1'b0, len} + (LEN_W+1)'(TAIL_LEN);
    assign last_step    = {1'b0, len} - (LEN_W+1)'(1);
    assign in_frame     = (state == S_RUN) || (state == S_FLUSH) || (state == S_DRAIN);
    assign dec_complete = (dec_cnt == dec_target);
    assign wdog_expire  = (state == S_DRAIN) && !dec_complete && !iAbort &&
                          (wdog == WD_W'(DRAIN_MAX - 1));

    // Flush and drain step every cycle; RUN only steps on an accepted symbol.
    assign dec_en     = ((state == S_RUN) && iSymValid) || (state == S_FLUSH) || (state == S_DRAIN);
    assign oDecEn     = dec_en;
    assign oSymReady  = (state == S_RUN);
    assign oFlush     = (state == S_FLUSH) || (state == S_DRAIN);
    assign oCounter   = counter;
    assign oCntZero   = dec_en && (counter == '1);
    assign oBusy      = (state != S_IDLE);
    assign oFrameDone = (state == S_DONE);
    assign oErr       = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iStart && (iFrameLen != '0)) state_nxt = S_RUN;
            S_RUN:   if (iSymValid && (step_cnt == last_step)) state_nxt = S_FLUSH;
            S_FLUSH: if (tail_cnt == TL_W'(TAIL_LEN - 1)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (dec_complete)
                    state_nxt = S_DONE;
                else if (wdog == WD_W'(DRAIN_MAX - 1))
                    state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (iAbort)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= S_IDLE;
            len      <= '0;
            step_cnt <= '0;
            dec_cnt  <= '0;
            tail_cnt <= '0;
            wdog     <= '0;
            counter  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= wdog_expire;
            if (iAbort) begin
                counter <= '0;
            end else if (start_ok) begin
                len      <= iFrameLen;
                step_cnt <= '0;
                dec_cnt  <= '0;
                tail_cnt <= '0;
                wdog     <= '0;
                counter  <= '0;
            end else begin
                if (dec_en)
                    counter <= counter + CNT_W'(1);
                if ((state == S_RUN) && iSymValid)
                    step_cnt <= step_cnt + (LEN_W+1)'(1);
                if (state == S_FLUSH)
                    tail_cnt <= tail_cnt + TL_W'(1);
                if (state == S_DRAIN)
                    wdog <= wdog + WD_W'(1);
                // Decoded-bit count saturates at the frame target.
                if (in_frame && iDecValid && !dec_complete)
                    dec_cnt <= dec_cnt + (LEN_W+1)'(1);
            end
        end
    end

`ifdef VITCTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if ((state == S_RUN) && !iSymValid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign oStallCnt = stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_viterbi_seq_ctrl.sv
`default_nettype none
// tb_viterbi_seq_ctrl - randomized scoreboard bench for viterbi_seq_ctrl.
module tb_viterbi_seq_ctrl;

    localparam int LEN_W = 16;
    localparam int CNT_W = 5;
    localparam int TAIL  = 6;
    localparam int DMAX  = 256;
    localparam int BLK   = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sym_valid = 1'b0;
    logic dec_valid = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic sym_ready, dec_en, flush, cnt_zero, busy, frame_done, err;
    logic [CNT_W-1:0] counter;
`ifdef VITCTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             fl;
        logic             zero;
        logic             ready;
    } step_t;

    step_t step_q[$];
    int    end_q[$];     // 0 = frame done, 1 = watchdog error

    int dsent, dtarget, ndec_plan;
    bit reached;

    step_t mon_e;
    int    mon_k;

    always #5 clk = ~clk;

    viterbi_seq_ctrl #(
        .LEN_W(LEN_W), .CNT_W(CNT_W), .TAIL_LEN(TAIL), .DRAIN_MAX(DMAX)
    ) dut (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iFrameLen(frame_len),
        .iAbort(abort), .iSymValid(sym_valid), .oSymReady(sym_ready),
        .oDecEn(dec_en), .oFlush(flush), .oCounter(counter), .oCntZero(cnt_zero),
        .iDecValid(dec_valid), .oBusy(busy), .oFrameDone(frame_done), .oErr(err)
`ifdef VITCTRL_STALL_CNT_EN
        , .oStallCnt(stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step k of a frame (k counted from the first step after start).
    function automatic step_t mk_step(input int k, input bit fl);
        step_t s;
        s.cnt   = CNT_W'(k % BLK);
        s.fl    = fl;
        s.zero  = ((k % BLK) == BLK - 1);
        s.ready = !fl;
        return s;
    endfunction

    task automatic drive_dec(input int pct);
        dec_valid = 1'b0;
        if (dsent < ndec_plan && int'($urandom_range(99)) < pct) begin
            dec_valid = 1'b1;
            dsent++;
            if (dsent == dtarget) reached = 1'b1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT steps or ends a frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dec_en) begin
                if (step_q.size() == 0) begin
                    check("unexpected_step", 32'd1, 32'd0);
                end else begin
                    mon_e = step_q.pop_front();
                    check("step_counter", 32'(counter), 32'(mon_e.cnt));
                    check("step_flush", 32'(flush), 32'(mon_e.fl));
                    check("step_cntzero", 32'(cnt_zero), 32'(mon_e.zero));
                    check("step_symready", 32'(sym_ready), 32'(mon_e.ready));
                end
            end
            if (frame_done || err) begin
                if (end_q.size() == 0) begin
                    check("unexpected_end", 32'd1, 32'd0);
                end else begin
                    mon_k = end_q.pop_front();
                    check("end_done", 32'(frame_done), 32'(mon_k == 0));
                    check("end_err", 32'(err), 32'(mon_k == 1));
                end
            end
        end
    end

    // vmode < 0: symbol valid toggles 1/0; otherwise percent probability.
    task automatic run_frame(input int L, input int vmode, input int ndec,
                             input int abort_f, input bit start_noise);
        int  k = 0;
        int  stalls = 0;
        int  i = 0;
        bit  v;
        bit  tog = 1'b1;
        bit  fin = 1'b0;
        bit  done_now;
        dsent = 0; dtarget = L + TAIL; ndec_plan = ndec; reached = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; frame_len = LEN_W'(L); sym_valid = 1'b0; dec_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (k < L) begin
            if (vmode < 0) begin v = tog; tog = !tog; end
            else v = (int'($urandom_range(99)) < vmode);
            sym_valid = v;
            drive_dec(25);
            if (start_noise) begin
                start = ($urandom_range(7) == 0);
                frame_len = LEN_W'($urandom);
            end
            if (v) begin step_q.push_back(mk_step(k, 1'b0)); k++; end
            else stalls++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int f = 0; f < TAIL; f++) begin
            sym_valid = 1'($urandom_range(1));
            drive_dec(25);
            step_q.push_back(mk_step(k, 1'b1));
            k++;
            if (f == abort_f) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; dec_valid = 1'b0; sym_valid = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_counter", 32'(counter), 32'd0);
                return;
            end
            @(posedge clk); #1;
        end
        while (!fin) begin
            done_now = reached;
            sym_valid = 1'($urandom_range(1));
            step_q.push_back(mk_step(k, 1'b1));
            k++;
            drive_dec(40);
            if (done_now) begin end_q.push_back(0); fin = 1'b1; end
            else if (i == DMAX - 1) begin end_q.push_back(1); fin = 1'b1; end
            @(posedge clk); #1;
            i++;
        end
        dec_valid = 1'b0; sym_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_after_frame", 32'(busy), 32'd0);
`ifdef VITCTRL_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_counter"}, 32'(counter), 32'd0);
        check({tag, "_decen_flush"}, {30'd0, dec_en, flush}, 32'd0);
        check({tag, "_ready_zero"}, {30'd0, sym_ready, cnt_zero}, 32'd0);
        check({tag, "_done_err"}, {30'd0, frame_done, err}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int L, vm, nd, sel;
        #2;
        reset_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted mid-RUN.
        start = 1'b1; frame_len = 16'd40; sym_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step_q.push_back(mk_step(k, 1'b0));
            @(posedge clk); #1;
        end
        sym_valid = 1'b0; rst_n = 1'b0;
        #1;
        reset_outputs_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_busy", 32'(busy), 32'd0);

        run_frame(40, 100, 46, -1, 1'b0);   // full-rate frame, all bits decoded
        run_frame(10, -1, 16, -1, 1'b0);    // toggling valid, 9 stalls
        run_frame(10, 100, 0, -1, 1'b0);    // no decoded bits: watchdog error
        run_frame(40, 100, 46, 3, 1'b0);    // abort during flush

        @(posedge clk); #1;
        start = 1'b1; frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd0);
        start = 1'b1; frame_len = 16'd5; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);

        run_frame(1, 100, 7, -1, 1'b1);     // shortest frame

        for (int n = 0; n < 10; n++) begin
            L   = int'($urandom_range(70, 1));
            vm  = int'($urandom_range(100, 30));
            sel = int'($urandom_range(3));
            nd  = (sel == 0) ? L + TAIL + 2 : (sel == 1) ? L + TAIL - 2 : L + TAIL;
            run_frame(L, vm, nd, -1, 1'b1);
        end

        repeat (3) @(posedge clk);
        check("step_q_empty", 32'(step_q.size()), 32'd0);
        check("end_q_empty", 32'(end_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
